pipe_flow_ctrl: RTL and testbench

Parametrised program-flow controller for the 16-bit pipelined core, replacing ad-hoc flush logic in the decode-stage control path. Keeps an instruction history shift register (ID/EX/MEM...) and resolves conditional branches from ALU flags. It drives PC select/hold and ID-stage kill for B, JAL, JR and multi-instruction EXEC windows, and honours a hazard stall. Sits between the instruction fetch register and the main decode/control unit.

---
 rtl/pipe_flow_ctrl_if.sv | 27 ++
 rtl/pipe_flow_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_flow_ctrl_if.sv
// Signal bundle between the fetch/decode path and pipe_flow_ctrl.
// master = fetch/decode side that supplies instructions and flags; slave = the controller.
interface pipe_flow_ctrl_if #(
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] instr_in;
    logic [2:0]         flag;
    logic               hazard;
    logic [1:0]         pc_sel;
    logic               pc_hold;
    logic               id_kill;
    logic [INSTR_W-1:0] instr_ex;
    logic [1:0]         state_o;
    logic [CNT_W-1:0]   taken_cnt;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output instr_in, flag, hazard,
        input  pc_sel, pc_hold, id_kill, instr_ex, state_o, taken_cnt, stall_cnt
    );

    modport slave (
        input  instr_in, flag, hazard,
        output pc_sel, pc_hold, id_kill, instr_ex, state_o, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Program-flow controller: instruction history, branch resolution, PC select/hold and ID kill.
// Define PFC_PERF_CNT_EN to build the saturating taken/stall performance counters.
module pipe_flow_ctrl #(
    parameter int INSTR_W      = 16,
    parameter int HIST_DEPTH   = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int EXEC_LEN     = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_flow_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_EXEC_JMP = 2'd2,
        ST_EXEC_RUN = 2'd3
    } state_e;

    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_EXEC = 4'hF;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_REG = 2'd2;
    localparam logic [1:0] PC_JAL = 2'd3;

    localparam logic [INSTR_W-1:0] NOP = '0;

    state_e             state_q, state_d;
    logic [1:0]         flush_cnt_q, flush_cnt_d;
    logic [3:0]         exec_cnt_q, exec_cnt_d;
    logic [INSTR_W-1:0] hist_q [1:HIST_DEPTH-1];
    logic [INSTR_W-1:0] hist_d [1:HIST_DEPTH-1];

    logic [3:0] ex_op;
    logic [3:0] ex_cond;
    logic       flag_z, flag_v, flag_n;
    logic       br_taken;
    logic       id_ctrl_op;
    logic       redirect;
    logic       shift_en;
    logic [1:0] pc_sel;
    logic       pc_hold;
    logic       id_kill;

    assign ex_op                    = hist_q[1][INSTR_W-1 -: 4];
    assign ex_cond                  = hist_q[1][INSTR_W-5 -: 4];
    assign {flag_z, flag_v, flag_n} = bus.flag;
    // Any B/JAL/JR/EXEC opcode in ID; such ops are not allowed inside an EXEC window.
    assign id_ctrl_op               = (bus.instr_in[INSTR_W-1 -: 2] == 2'b11);

    always_comb begin
        case (ex_cond)
            4'd0:    br_taken = flag_z;
            4'd1:    br_taken = !flag_z;
            4'd2:    br_taken = !flag_n && !flag_z;
            4'd3:    br_taken = flag_n;
            4'd4:    br_taken = flag_z || (!flag_n && !flag_z);
            4'd5:    br_taken = flag_n || flag_z;
            4'd6:    br_taken = flag_v;
            4'd7:    br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        exec_cnt_d  = exec_cnt_q;
        pc_sel      = PC_INC;
        pc_hold     = 1'b0;
        id_kill     = 1'b0;
        redirect    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if ((ex_op == OP_B && br_taken) || ex_op == OP_JAL || ex_op == OP_JR) begin
                    redirect = 1'b1;
                    id_kill  = 1'b1;
                    if (ex_op == OP_B) begin
                        pc_sel = PC_BR;
                    end else if (ex_op == OP_JAL) begin
                        pc_sel = PC_JAL;
                    end else begin
                        pc_sel = PC_REG;
                    end
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = 2'(FLUSH_CYCLES - 1);
                    end
                end else if (ex_op == OP_EXEC) begin
                    // Hold PC one cycle so the register target can be loaded next cycle.
                    redirect = 1'b1;
                    pc_sel   = PC_REG;
                    pc_hold  = 1'b1;
                    id_kill  = 1'b1;
                    state_d  = ST_EXEC_JMP;
                end
            end

            ST_FLUSH: begin
                id_kill     = 1'b1;
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                end
            end

            ST_EXEC_JMP: begin
                pc_sel     = PC_REG;
                id_kill    = 1'b1;
                exec_cnt_d = 4'(EXEC_LEN);
                state_d    = ST_EXEC_RUN;
            end

            ST_EXEC_RUN: begin
                id_kill    = id_ctrl_op;
                exec_cnt_d = exec_cnt_q - 4'd1;
                if (exec_cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                end else begin
                    pc_sel = PC_REG;
                end
            end
        endcase

        // A stall freezes everything unless a redirect is already discarding the ID slot.
        shift_en = redirect || !bus.hazard;
        if (!shift_en) begin
            state_d     = state_q;
            flush_cnt_d = flush_cnt_q;
            exec_cnt_d  = exec_cnt_q;
            pc_hold     = 1'b1;
            id_kill     = 1'b1;
        end
    end

    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d[1] = id_kill ? NOP : bus.instr_in;
            for (int k = 2; k < HIST_DEPTH; k++) begin
                hist_d[k] = hist_q[k-1];
            end
        end
    end

    // NOTE: the history is a short flop chain rather than a RAM, so it is reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            exec_cnt_q  <= '0;
            hist_q      <= '{default: NOP};
        end else begin
            // NOTE: sequential state uses non-blocking '<=' only; blocking '=' stays in always_comb.
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            exec_cnt_q  <= exec_cnt_d;
            hist_q      <= hist_d;
        end
    end

`ifdef PFC_PERF_CNT_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (redirect && !(&taken_cnt_q)) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
        if (!shift_en && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.taken_cnt = taken_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.taken_cnt = {CNT_W{1'b0}};
    assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

    assign bus.pc_sel   = pc_sel;
    assign bus.pc_hold  = pc_hold;
    assign bus.id_kill  = id_kill;
    assign bus.instr_ex = hist_q[1];
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Scoreboard bench for pipe_flow_ctrl (FLUSH_CYCLES=3, EXEC_LEN=2): hand-derived per-cycle
// expectations are queued as stimulus is driven and popped when the outputs are sampled.
module tb_pipe_flow_ctrl;

    localparam int W = 16;
`ifdef PFC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]   pc_sel;
        logic         pc_hold;
        logic         id_kill;
        logic [1:0]   state;
        logic [W-1:0] instr_ex;
        logic [15:0]  taken;
        logic [15:0]  stall;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] instr;
        logic [2:0]   flag;
        logic         hazard;
        exp_t         want;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    vec_t vecs_a[$];
    vec_t vecs_b[$];

    pipe_flow_ctrl_if #(.INSTR_W(W), .CNT_W(16)) bus ();

    pipe_flow_ctrl #(
        .INSTR_W      (W),
        .HIST_DEPTH   (3),
        .FLUSH_CYCLES (3),
        .EXEC_LEN     (2),
        .CNT_W        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] sel, input logic hold, input logic kill,
                                input logic [1:0] st, input logic [W-1:0] ex,
                                input int tk, input int sl);
        exp_t e;
        e.pc_sel   = sel;
        e.pc_hold  = hold;
        e.id_kill  = kill;
        e.state    = st;
        e.instr_ex = ex;
        e.taken    = PERF ? 16'(tk) : 16'd0;
        e.stall    = PERF ? 16'(sl) : 16'd0;
        return e;
    endfunction

    function automatic vec_t mv(input logic [W-1:0] instr, input logic [2:0] flag, input logic haz,
                                input logic [1:0] sel, input logic hold, input logic kill,
                                input logic [1:0] st, input logic [W-1:0] ex,
                                input int tk, input int sl);
        vec_t v;
        v.instr  = instr;
        v.flag   = flag;
        v.hazard = haz;
        v.want   = mk(sel, hold, kill, st, ex, tk, sl);
        return v;
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        check({tag, ".pc_sel"},    32'(bus.pc_sel),    32'(e.pc_sel));
        check({tag, ".pc_hold"},   32'(bus.pc_hold),   32'(e.pc_hold));
        check({tag, ".id_kill"},   32'(bus.id_kill),   32'(e.id_kill));
        check({tag, ".state"},     32'(bus.state_o),   32'(e.state));
        check({tag, ".instr_ex"},  32'(bus.instr_ex),  32'(e.instr_ex));
        check({tag, ".taken_cnt"}, 32'(bus.taken_cnt), 32'(e.taken));
        check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(e.stall));
    endtask

    task automatic run_step(input vec_t v, input int idx);
        @(negedge clk);
        bus.instr_in = v.instr;
        bus.flag     = v.flag;
        bus.hazard   = v.hazard;
        exp_q.push_back(v.want);
        #2;
        compare_pop($sformatf("s%0d", idx));
    endtask

    initial begin
        rst          = 1'b1;
        bus.instr_in = '0;
        bus.flag     = '0;
        bus.hazard   = 1'b0;

        // instr, flag{Z,V,N}, hazard | pc_sel, hold, kill, state, instr_ex | taken, stall
        vecs_a.push_back(mv(16'h1234, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 0, 0));
        vecs_a.push_back(mv(16'hC0AA, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h1234, 0, 0));
        vecs_a.push_back(mv(16'h5555, 3'd4, 1'b0, 2'd1, 1'b0, 1'b1, 2'd0, 16'hC0AA, 0, 0));
        vecs_a.push_back(mv(16'h6666, 3'd4, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 16'h0000, 1, 0));
        vecs_a.push_back(mv(16'h7777, 3'd4, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 16'h0000, 1, 0));
        vecs_a.push_back(mv(16'h8888, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 1, 0));
        vecs_a.push_back(mv(16'hC1BB, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h8888, 1, 0));
        vecs_a.push_back(mv(16'h2468, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'hC1BB, 1, 0));
        vecs_a.push_back(mv(16'hC8CC, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h2468, 1, 0));
        vecs_a.push_back(mv(16'hABCD, 3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'hC8CC, 1, 0));
        vecs_a.push_back(mv(16'h1111, 3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 16'hABCD, 1, 0));
        vecs_a.push_back(mv(16'h1111, 3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 16'hABCD, 1, 1));
        vecs_a.push_back(mv(16'h1111, 3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 16'hABCD, 1, 2));
        vecs_a.push_back(mv(16'h1111, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'hABCD, 1, 3));
        vecs_a.push_back(mv(16'hE300, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h1111, 1, 3));
        vecs_a.push_back(mv(16'h2222, 3'd0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd0, 16'hE300, 1, 3));
        vecs_a.push_back(mv(16'h3333, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 16'h0000, 2, 3));
        vecs_a.push_back(mv(16'h3333, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 16'h0000, 2, 3));
        vecs_a.push_back(mv(16'hD000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 2, 3));
        vecs_a.push_back(mv(16'h4444, 3'd0, 1'b0, 2'd3, 1'b0, 1'b1, 2'd0, 16'hD000, 2, 3));
        vecs_a.push_back(mv(16'h4444, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 16'h0000, 3, 3));
        vecs_a.push_back(mv(16'h4444, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 16'h0000, 3, 3));
        vecs_a.push_back(mv(16'hF012, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 3, 3));
        vecs_a.push_back(mv(16'h9999, 3'd0, 1'b0, 2'd2, 1'b1, 1'b1, 2'd0, 16'hF012, 3, 3));
        vecs_a.push_back(mv(16'h9999, 3'd0, 1'b0, 2'd2, 1'b0, 1'b1, 2'd2, 16'h0000, 4, 3));
        vecs_a.push_back(mv(16'hC7AA, 3'd0, 1'b0, 2'd2, 1'b0, 1'b1, 2'd3, 16'h0000, 4, 3));
        vecs_a.push_back(mv(16'h5A5A, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 16'h0000, 4, 3));
        vecs_a.push_back(mv(16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h5A5A, 4, 3));
        vecs_a.push_back(mv(16'hF000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 4, 3));
        vecs_a.push_back(mv(16'h1234, 3'd0, 1'b0, 2'd2, 1'b1, 1'b1, 2'd0, 16'hF000, 4, 3));
        vecs_a.push_back(mv(16'h1234, 3'd0, 1'b0, 2'd2, 1'b0, 1'b1, 2'd2, 16'h0000, 5, 3));
        vecs_a.push_back(mv(16'h7777, 3'd0, 1'b0, 2'd2, 1'b0, 1'b0, 2'd3, 16'h0000, 5, 3));

        vecs_b.push_back(mv(16'h4321, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 0, 0));
        vecs_b.push_back(mv(16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h4321, 0, 0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 0, 0));
        compare_pop("reset");

        foreach (vecs_a[i]) run_step(vecs_a[i], i + 1);

        // Asynchronous reset while the EXEC window is still open, away from any clock edge.
        #1;
        rst = 1'b1;
        #1;
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 0, 0));
        compare_pop("async_rst");

        @(negedge clk);
        bus.instr_in = '0;
        bus.hazard   = 1'b0;
        rst          = 1'b0;

        foreach (vecs_b[i]) run_step(vecs_b[i], 33 + i);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
